// File: rtl/anti_theft_ctrl_if.sv
// Sensor inputs and indicator outputs of the anti-theft sequencer.
// one_hz_enable is a single-cycle strobe; there is no valid/ready handshake on this bus.
interface anti_theft_ctrl_if;
  logic       one_hz_enable;
  logic       ignition;
  logic       driver_door;
  logic       passenger_door;
  logic       siren;
  logic       status_led;
  logic       armed;
  logic [2:0] state_dbg;

  modport master (
    output one_hz_enable, ignition, driver_door, passenger_door,
    input  siren, status_led, armed, state_dbg
  );

  modport slave (
    input  one_hz_enable, ignition, driver_door, passenger_door,
    output siren, status_led, armed, state_dbg
  );
endinterface

// File: rtl/anti_theft_ctrl.sv
// Car-alarm sequencer: arms after the driver leaves, runs entry/alarm countdowns
// from a seconds down-counter, drives siren, status LED and the fuel-gate armed flag.
module anti_theft_ctrl #(
    parameter int T_ARM_DELAY       = 6,
    parameter int T_DRIVER_DELAY    = 8,
    parameter int T_PASSENGER_DELAY = 15,
    parameter int T_ALARM_ON        = 10,
    parameter int TW                = 4
) (
    input  logic               clk,
    input  logic               reset,
    anti_theft_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ARMED      = 3'd0,
        TRIGGERED  = 3'd1,
        ALARM      = 3'd2,
        ALARM_HOLD = 3'd3,
        DISARMED   = 3'd4,
        WAIT_OPEN  = 3'd5,
        WAIT_CLOSE = 3'd6,
        ARM_DELAY  = 3'd7
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] count;
    logic [TW-1:0] load_val;
    logic          load;
    logic          expired;
    logic          tick;
    logic          led_phase;
    logic          siren_q, led_q, armed_q;
    logic [2:0]    dbg_q;

    assign tick    = bus.one_hz_enable;
    assign expired = (count == '0) && tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ARMED;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        load_val = '0;
        case (state)
            ARMED: begin
                if (bus.driver_door) begin
                    state_n  = TRIGGERED;
                    load     = 1'b1;
                    load_val = TW'(T_DRIVER_DELAY);
                end else if (bus.passenger_door) begin
                    state_n  = TRIGGERED;
                    load     = 1'b1;
                    load_val = TW'(T_PASSENGER_DELAY);
                end
            end
            TRIGGERED: if (expired) state_n = ALARM;
            ALARM: begin
                if (!bus.driver_door && !bus.passenger_door) begin
                    state_n  = ALARM_HOLD;
                    load     = 1'b1;
                    load_val = TW'(T_ALARM_ON);
                end
            end
            ALARM_HOLD: begin
                // A reopened door beats a same-cycle expiry.
                if (bus.driver_door || bus.passenger_door) state_n = ALARM;
                else if (expired)                          state_n = ARMED;
            end
            DISARMED:   if (!bus.ignition) state_n = WAIT_OPEN;
            WAIT_OPEN:  if (bus.driver_door) state_n = WAIT_CLOSE;
            WAIT_CLOSE: begin
                if (!bus.driver_door) begin
                    state_n  = ARM_DELAY;
                    load     = 1'b1;
                    load_val = TW'(T_ARM_DELAY);
                end
            end
            ARM_DELAY: begin
                if (bus.driver_door || bus.passenger_door) state_n = WAIT_CLOSE;
                else if (expired)                          state_n = ARMED;
            end
            default: state_n = ARMED;
        endcase
        if (bus.ignition) begin
            state_n = DISARMED;
            load    = 1'b0;
        end
    end

    // Load has priority over a coincident tick, so a load of N expires on tick N+1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   count <= '0;
        else if (load)               count <= load_val;
        else if (tick && count != 0) count <= count - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   led_phase <= 1'b0;
        else if (state_n != ARMED)   led_phase <= 1'b0;
        else if (state != ARMED)     led_phase <= 1'b0;
        else if (tick)               led_phase <= ~led_phase;
    end

    // Outputs are registered from the current state, trailing it by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            siren_q <= 1'b0;
            led_q   <= 1'b0;
            armed_q <= 1'b1;
            dbg_q   <= 3'd0;
        end else begin
            siren_q <= (state == ALARM) || (state == ALARM_HOLD);
            armed_q <= (state == ARMED) || (state == TRIGGERED) ||
                       (state == ALARM) || (state == ALARM_HOLD);
            led_q   <= (state == ARMED) ? led_phase :
                       ((state == TRIGGERED) || (state == ALARM) || (state == ALARM_HOLD));
            dbg_q   <= state;
        end
    end

    assign bus.siren      = siren_q;
    assign bus.status_led = led_q;
    assign bus.armed      = armed_q;
    assign bus.state_dbg  = dbg_q;

endmodule

// File: tb/tb_anti_theft_ctrl.sv
// Directed bench for anti_theft_ctrl: entry/alarm/arm countdowns, ignition override,
// led toggling, load-vs-tick collision and asynchronous reset.
module tb_anti_theft_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  anti_theft_ctrl_if bus ();

  anti_theft_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    bus.one_hz_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.one_hz_enable = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic sir,
                           input logic led, input logic arm);
    check({tag, "_state"}, {1'b0, bus.state_dbg}, {1'b0, st});
    check({tag, "_siren"}, {3'b0, bus.siren}, {3'b0, sir});
    check({tag, "_led"},   {3'b0, bus.status_led}, {3'b0, led});
    check({tag, "_armed"}, {3'b0, bus.armed}, {3'b0, arm});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.one_hz_enable  = 1'b0;
    bus.ignition       = 1'b0;
    bus.driver_door    = 1'b0;
    bus.passenger_door = 1'b0;

    // reset and led toggling in ARMED
    reset = 1'b1;
    cyc(3);
    check_all("rst", 3'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    cyc(2);
    check_all("armed_idle", 3'd0, 1'b0, 1'b0, 1'b1);
    tick(); cyc(1);
    check("led_tog1", {3'b0, bus.status_led}, 4'd1);
    tick(); cyc(1);
    check("led_tog2", {3'b0, bus.status_led}, 4'd0);

    // driver entry: siren on tick 9
    bus.driver_door = 1'b1;
    cyc(2);
    check_all("trig_drv", 3'd1, 1'b0, 1'b1, 1'b1);
    bus.driver_door = 1'b0;
    ticks(8); cyc(2);
    check_all("trig_t8", 3'd1, 1'b0, 1'b1, 1'b1);
    tick(); cyc(1);
    check_all("alarm_t9", 3'd2, 1'b1, 1'b1, 1'b1);

    // doors already closed -> ALARM_HOLD; reopen at tick 4 -> ALARM
    cyc(1);
    check("hold_entry", {1'b0, bus.state_dbg}, 4'd3);
    ticks(4);
    bus.passenger_door = 1'b1;
    cyc(2);
    check_all("hold_reopen", 3'd2, 1'b1, 1'b1, 1'b1);
    bus.passenger_door = 1'b0;
    cyc(2);
    check("hold_again", {1'b0, bus.state_dbg}, 4'd3);
    ticks(10); cyc(2);
    check_all("hold_t10", 3'd3, 1'b1, 1'b1, 1'b1);
    tick(); cyc(1);
    check_all("hold_t11", 3'd0, 1'b0, 1'b0, 1'b1);

    // passenger entry: siren on tick 16
    bus.passenger_door = 1'b1;
    cyc(1);
    bus.passenger_door = 1'b0;
    cyc(1);
    check("trig_pas", {1'b0, bus.state_dbg}, 4'd1);
    ticks(15); cyc(2);
    check("pas_t15_siren", {3'b0, bus.siren}, 4'd0);
    tick(); cyc(1);
    check("pas_t16_siren", {3'b0, bus.siren}, 4'd1);

    // asynchronous reset mid-alarm, no clock edge in between
    cyc(2);
    reset = 1'b1;
    #1;
    check_all("async_rst", 3'd0, 1'b0, 1'b0, 1'b1);
    cyc(1);
    reset = 1'b0;
    cyc(2);
    check("post_rst_state", {1'b0, bus.state_dbg}, 4'd0);

    // ignition during TRIGGERED at tick 5 -> DISARMED, no siren
    bus.driver_door = 1'b1;
    cyc(1);
    bus.driver_door = 1'b0;
    ticks(4);
    bus.ignition = 1'b1;
    tick(); cyc(1);
    check_all("ign_disarm", 3'd4, 1'b0, 1'b0, 1'b0);
    ticks(10); cyc(1);
    check_all("ign_hold", 3'd4, 1'b0, 1'b0, 1'b0);

    // driver leaves: WAIT_OPEN, passenger alone ignored
    bus.ignition = 1'b0;
    cyc(2);
    check("wait_open", {1'b0, bus.state_dbg}, 4'd5);
    bus.passenger_door = 1'b1;
    cyc(2);
    check("wait_open_pas", {1'b0, bus.state_dbg}, 4'd5);
    bus.passenger_door = 1'b0;
    bus.driver_door = 1'b1;
    cyc(2);
    check("wait_close", {1'b0, bus.state_dbg}, 4'd6);
    bus.driver_door = 1'b0;
    cyc(2);
    check_all("arm_delay", 3'd7, 1'b0, 1'b0, 1'b0);

    // reopen at tick 3 restarts the delay; close coincides with a tick (load wins)
    ticks(3);
    bus.driver_door = 1'b1;
    cyc(2);
    check("arm_reopen", {1'b0, bus.state_dbg}, 4'd6);
    bus.driver_door = 1'b0;
    tick();
    ticks(6); cyc(2);
    check_all("arm_t6", 3'd7, 1'b0, 1'b0, 1'b0);
    tick(); cyc(1);
    check_all("arm_t7", 3'd0, 1'b0, 1'b0, 1'b1);

    // both doors at once from ARMED -> driver delay (expires on tick 9)
    bus.driver_door = 1'b1;
    bus.passenger_door = 1'b1;
    cyc(1);
    bus.driver_door = 1'b0;
    bus.passenger_door = 1'b0;
    ticks(8); cyc(2);
    check("both_t8", {1'b0, bus.state_dbg}, 4'd1);
    tick(); cyc(1);
    check("both_t9", {1'b0, bus.state_dbg}, 4'd2);

    // ignition overrides from ALARM
    bus.ignition = 1'b1;
    cyc(2);
    check_all("ign_alarm", 3'd4, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
